// File: rtl/cache_arbiter_if.sv
// Bus bundle between cache_arbiter, the I/D caches and the L2 cache.
// slave: arbiter side; master: the environment driving caches and L2.
interface cache_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic              icache_resp;
  logic [LINE_W-1:0] icache_rdata;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic              dcache_resp;
  logic [LINE_W-1:0] dcache_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  mem_resp, mem_rdata,
    output icache_resp, icache_rdata,
    output dcache_resp, dcache_rdata,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output mem_resp, mem_rdata,
    input  icache_resp, icache_rdata,
    input  dcache_resp, dcache_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/writebacks onto a single L2 port.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the D-cache always wins.
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StServeI, StServeD, StRespI, StRespD} state_e;

  state_e            state_q, state_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic i_req, d_req, grant_d, take, serving;

  assign i_req   = bus.icache_read;
  assign d_req   = bus.dcache_read | bus.dcache_write;
  assign take    = (state_q == StIdle) && (i_req || d_req);
  assign serving = (state_q == StServeI) || (state_q == StServeD);

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the D-cache; reset leaves it on I.
  logic last_grant_d_q, last_grant_d_d;

  assign grant_d = d_req & (~i_req | ~last_grant_d_q);

  always_comb begin
    last_grant_d_d = last_grant_d_q;
    if (take) begin
      last_grant_d_d = grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d_q <= 1'b0;
    end else begin
      last_grant_d_q <= last_grant_d_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d = grant_d ? StServeD : StServeI;
        end
      end
      StServeI: begin
        if (bus.mem_resp) begin
          state_d = StRespI;
        end
      end
      StServeD: begin
        if (bus.mem_resp) begin
          state_d = StRespD;
        end
      end
      StRespI, StRespD: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  // Request latch and returned line; held stable for the whole transaction.
  always_comb begin
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    if (take) begin
      if (grant_d) begin
        op_write_d = bus.dcache_write;
        addr_d     = bus.dcache_address;
        wdata_d    = bus.dcache_wdata;
      end else begin
        op_write_d = 1'b0;
        addr_d     = bus.icache_address;
        wdata_d    = '0;
      end
    end
    if (serving && bus.mem_resp) begin
      line_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
    end else begin
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
    end
  end

  // Output decode from registered state only
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.icache_resp = 1'b0;
    bus.dcache_resp = 1'b0;
    unique case (state_q)
      StServeI, StServeD: begin
        bus.mem_read  = ~op_write_q;
        bus.mem_write = op_write_q;
      end
      StRespI: bus.icache_resp = 1'b1;
      StRespD: bus.dcache_resp = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_address  = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.icache_rdata = line_q;
  assign bus.dcache_rdata = line_q;

  a_mem_op_onehot: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_read && bus.mem_write));

  a_resp_onehot: assert property (@(posedge clk) disable iff (rst)
    !(bus.icache_resp && bus.dcache_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random traffic against a transaction model.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
module tb_cache_arbiter;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   model_last_d;  // true when the model's last grant went to D

  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Winner under simultaneous or single requests, straight from the arbitration rules.
  function automatic bit pick_d(bit pi, bit pd);
    return pd && (!pi || (RR ? !model_last_d : 1'b1));
  endfunction

  task automatic idle_inputs();
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.mem_resp       = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.icache_read  = 1'b1;
    bus.dcache_write = 1'b1;
    bus.mem_resp     = 1'b1;
    step();
    step();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000",
               {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
    end
    checks++;
    if (bus.mem_address !== '0 || bus.mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_addr_wdata got addr=%h wdata=%h exp 0", bus.mem_address, bus.mem_wdata);
    end
    checks++;
    if (bus.icache_rdata !== '0 || bus.dcache_rdata !== '0) begin
      failures++;
      $display("FAIL reset_line got i=%h d=%h exp 0", bus.icache_rdata, bus.dcache_rdata);
    end
    rst = 1'b0;
    idle_inputs();
    model_last_d = 1'b0;
    step();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_no_req got=%b exp=0000",
               {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
    end
  endtask

  task automatic test_i_read();
    logic [LW-1:0] line = {32{8'hA5}};
    bus.icache_read    = 1'b1;
    bus.icache_address = 32'h0000_1000;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if ({bus.mem_read, bus.mem_write} !== 2'b10 || bus.mem_address !== 32'h0000_1000) begin
        failures++;
        $display("FAIL i_read_req c%0d got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=00001000",
                 c, bus.mem_read, bus.mem_write, bus.mem_address);
      end
      checks++;
      if ({bus.icache_resp, bus.dcache_resp} !== 2'b00) begin
        failures++;
        $display("FAIL i_read_early_resp c%0d got=%b exp=00", c,
                 {bus.icache_resp, bus.dcache_resp});
      end
      if (c == 3) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = line;
      end
    end
    step();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = rand_line();
    checks++;
    if ({bus.icache_resp, bus.dcache_resp, bus.mem_read, bus.mem_write} !== 4'b1000) begin
      failures++;
      $display("FAIL i_read_resp got iresp,dresp,rd,wr=%b exp=1000",
               {bus.icache_resp, bus.dcache_resp, bus.mem_read, bus.mem_write});
    end
    checks++;
    if (bus.icache_rdata !== line) begin
      failures++;
      $display("FAIL i_read_data got=%h exp=%h", bus.icache_rdata, line);
    end
    bus.icache_read = 1'b0;
    model_last_d    = 1'b0;
    for (int c = 5; c <= 6; c++) begin
      step();
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
        failures++;
        $display("FAIL i_read_idle c%0d got=%b exp=0000", c,
                 {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
      end
    end
  endtask

  task automatic test_d_write();
    logic [AW-1:0] addr  = 32'h0000_2040;
    logic [LW-1:0] wdata = {16{16'h1234}};
    logic [LW-1:0] line  = rand_line();
    int            resps = 0;
    bus.dcache_write   = 1'b1;
    bus.dcache_address = addr;
    bus.dcache_wdata   = wdata;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if ({bus.mem_read, bus.mem_write} !== 2'b01 || bus.mem_address !== addr ||
          bus.mem_wdata !== wdata) begin
        failures++;
        $display("FAIL d_write_req c%0d got rd=%b wr=%b addr=%h wdata=%h exp rd=0 wr=1 addr=%h",
                 c, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata, addr);
      end
      if (bus.dcache_resp === 1'b1) resps++;
      // Changes from the requester mid-transaction must not leak through
      bus.dcache_address = $urandom();
      bus.dcache_wdata   = rand_line();
      if (c == 5) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = line;
      end
    end
    step();
    bus.mem_resp = 1'b0;
    if (bus.dcache_resp === 1'b1) resps++;
    checks++;
    if ({bus.icache_resp, bus.dcache_resp, bus.mem_read, bus.mem_write} !== 4'b0100) begin
      failures++;
      $display("FAIL d_write_resp got iresp,dresp,rd,wr=%b exp=0100",
               {bus.icache_resp, bus.dcache_resp, bus.mem_read, bus.mem_write});
    end
    bus.dcache_write = 1'b0;
    model_last_d     = 1'b1;
    step();
    if (bus.dcache_resp === 1'b1) resps++;
    checks++;
    if (resps !== 1) begin
      failures++;
      $display("FAIL d_write_pulse_count got=%0d exp=1", resps);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] ai = 32'h0000_0100;
    logic [AW-1:0] ad = 32'h0000_0200;
    logic [LW-1:0] line;
    bit            exp_d;
    rst                = 1'b1;
    bus.icache_read    = 1'b1;
    bus.icache_address = ai;
    bus.dcache_read    = 1'b1;
    bus.dcache_address = ad;
    step();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
      failures++;
      $display("FAIL contend_reset got=%b exp=0000",
               {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
    end
    rst          = 1'b0;
    model_last_d = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (r == 3) bus.dcache_read = 1'b0;
      exp_d = pick_d(bus.icache_read, bus.dcache_read);
      step();
      checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== (exp_d ? ad : ai)) begin
        failures++;
        $display("FAIL contend_grant r%0d got rd=%b addr=%h exp rd=1 addr=%h",
                 r, bus.mem_read, bus.mem_address, exp_d ? ad : ai);
      end
      line          = rand_line();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = line;
      step();
      bus.mem_resp = 1'b0;
      checks++;
      if ({bus.icache_resp, bus.dcache_resp} !== (exp_d ? 2'b01 : 2'b10) ||
          (exp_d ? bus.dcache_rdata : bus.icache_rdata) !== line) begin
        failures++;
        $display("FAIL contend_resp r%0d got iresp,dresp=%b exp=%b", r,
                 {bus.icache_resp, bus.dcache_resp}, exp_d ? 2'b01 : 2'b10);
      end
      model_last_d = exp_d;
      if (r == 3) bus.icache_read = 1'b0;
      step();
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
        failures++;
        $display("FAIL contend_idle r%0d got=%b exp=0000", r,
                 {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
      end
    end
  endtask

  task automatic test_reset_mid_serve();
    bus.dcache_write   = 1'b1;
    bus.dcache_address = $urandom();
    bus.dcache_wdata   = rand_line();
    step();
    checks++;
    if (bus.mem_write !== 1'b1) begin
      failures++;
      $display("FAIL midrst_serve got wr=%b exp=1", bus.mem_write);
    end
    step();
    rst              = 1'b1;
    bus.dcache_write = 1'b0;
    step();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000 ||
        bus.mem_address !== '0 || bus.mem_wdata !== '0) begin
      failures++;
      $display("FAIL midrst_clear got ctrl=%b addr=%h exp ctrl=0000 addr=0",
               {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp}, bus.mem_address);
    end
    rst           = 1'b0;
    model_last_d  = 1'b0;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rand_line();
    for (int c = 0; c < 3; c++) begin
      step();
      bus.mem_resp = 1'b0;
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
        failures++;
        $display("FAIL midrst_late_resp c%0d got=%b exp=0000", c,
                 {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
      end
    end
  endtask

  task automatic test_rw_both_stray();
    logic [LW-1:0] line = rand_line();
    bus.dcache_read    = 1'b1;
    bus.dcache_write   = 1'b1;
    bus.dcache_address = $urandom();
    bus.dcache_wdata   = rand_line();
    step();
    checks++;
    if ({bus.mem_read, bus.mem_write} !== 2'b01) begin
      failures++;
      $display("FAIL rw_both_op got rd,wr=%b exp=01", {bus.mem_read, bus.mem_write});
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = line;
    step();
    bus.mem_resp     = 1'b0;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
    model_last_d     = 1'b1;
    checks++;
    if (bus.dcache_resp !== 1'b1 || bus.dcache_rdata !== line) begin
      failures++;
      $display("FAIL rw_both_resp got resp=%b data=%h exp resp=1 data=%h",
               bus.dcache_resp, bus.dcache_rdata, line);
    end
    step();
    bus.mem_resp = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
        failures++;
        $display("FAIL stray_resp c%0d got=%b exp=0000", c,
                 {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
      end
    end
    bus.mem_resp = 1'b0;
  endtask

  task automatic test_random();
    bit            pi, pd, dr, dw, win_d, exp_w;
    int            sel, lat;
    logic [AW-1:0] ai, ad, exp_addr;
    logic [LW-1:0] wd, rline;
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 2);
      pi  = (sel != 1);
      pd  = (sel != 0);
      ai  = $urandom();
      ad  = $urandom();
      wd  = rand_line();
      case ($urandom_range(0, 2))
        0:       {dr, dw} = 2'b10;
        1:       {dr, dw} = 2'b01;
        default: {dr, dw} = 2'b11;
      endcase
      bus.icache_read    = pi;
      bus.icache_address = ai;
      bus.dcache_read    = pd & dr;
      bus.dcache_write   = pd & dw;
      bus.dcache_address = ad;
      bus.dcache_wdata   = wd;
      while (pi || pd) begin
        win_d    = pick_d(pi, pd);
        exp_addr = win_d ? ad : ai;
        exp_w    = win_d && dw;
        lat      = $urandom_range(1, 4);
        rline    = rand_line();
        for (int c = 1; c <= lat; c++) begin
          step();
          checks++;
          if ({bus.mem_read, bus.mem_write} !== {!exp_w, exp_w} || bus.mem_address !== exp_addr ||
              (exp_w && bus.mem_wdata !== wd)) begin
            failures++;
            $display("FAIL rand_req r%0d c%0d got rd=%b wr=%b addr=%h exp rd=%b wr=%b addr=%h",
                     r, c, bus.mem_read, bus.mem_write, bus.mem_address, !exp_w, exp_w, exp_addr);
          end
          checks++;
          if ({bus.icache_resp, bus.dcache_resp} !== 2'b00) begin
            failures++;
            $display("FAIL rand_early_resp r%0d c%0d got=%b exp=00", r, c,
                     {bus.icache_resp, bus.dcache_resp});
          end
          if (win_d) begin
            bus.dcache_address = $urandom();
            bus.dcache_wdata   = rand_line();
          end else begin
            bus.icache_address = $urandom();
          end
          if (c == lat) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = rline;
          end
        end
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = rand_line();
        checks++;
        if ({bus.icache_resp, bus.dcache_resp, bus.mem_read, bus.mem_write} !==
            {!win_d, win_d, 2'b00}) begin
          failures++;
          $display("FAIL rand_resp r%0d got iresp,dresp,rd,wr=%b exp=%b", r,
                   {bus.icache_resp, bus.dcache_resp, bus.mem_read, bus.mem_write},
                   {!win_d, win_d, 2'b00});
        end
        checks++;
        if ((win_d ? bus.dcache_rdata : bus.icache_rdata) !== rline) begin
          failures++;
          $display("FAIL rand_data r%0d got=%h exp=%h", r,
                   win_d ? bus.dcache_rdata : bus.icache_rdata, rline);
        end
        model_last_d = win_d;
        if (win_d) begin
          pd               = 1'b0;
          bus.dcache_read  = 1'b0;
          bus.dcache_write = 1'b0;
        end else begin
          pi              = 1'b0;
          bus.icache_read = 1'b0;
        end
        if (!pi && !pd && ($urandom_range(0, 2) == 0)) bus.mem_resp = 1'b1;
        step();
        bus.mem_resp = 1'b0;
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000) begin
          failures++;
          $display("FAIL rand_idle r%0d got=%b exp=0000", r,
                   {bus.mem_read, bus.mem_write, bus.icache_resp, bus.dcache_resp});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_reset_mid_serve();
    test_rw_both_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
